// File: rtl/ztex_link_pkg.sv
// Shared constants, link FSM state encoding and result byte-order helper for the ZTEX host link.
package ztex_link_pkg;

   localparam int unsigned WORK_BYTES   = 44;
   localparam int unsigned RESULT_BYTES = 16;
   localparam int unsigned WORK_W       = WORK_BYTES * 8;
   localparam int unsigned RESULT_W     = RESULT_BYTES * 8;
   localparam int unsigned PACE_W       = 16;

   typedef enum logic [3:0] {
      StIdle, StWSetup, StWToggle, StTRst, StRStart, StRSettle, StRSample, StRToggle, StRDone
   } link_state_e;

   // Byte idx lands at bits [8*idx +: 8]; byte 0 is the first one on the wire.
   function automatic logic [RESULT_W-1:0] put_result_byte(input logic [RESULT_W-1:0] v,
                                                           input logic [3:0]          idx,
                                                           input logic [7:0]          b);
      logic [RESULT_W-1:0] r;
      r = v;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/ztex_link_pacer.sv
// Phase pacer: load a cycle count N, done is high on the N-th cycle after the load edge.
module ztex_link_pacer
   import ztex_link_pkg::*;
#(
   parameter int unsigned W = PACE_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign done = (cnt_q == W'(1));

endmodule

// File: rtl/ztex_host_link_master.sv
// Host end of the ZTEX byte-serial miner link: pushes 44-byte work, pulses target reset, polls
// the 16-byte result. Define HOST_LINK_READ_VERIFY_EN for double-read verification with retries.
module ztex_host_link_master
   import ztex_link_pkg::*;
#(
   parameter int unsigned DIV       = 8,
   parameter int unsigned START_CYC = 6,
   parameter int unsigned RST_CYC   = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                work_valid,
   output logic                work_ready,
   input  logic [WORK_W-1:0]   work_data,
   input  logic                poll_req,
   output logic                result_valid,
   output logic [RESULT_W-1:0] result,
   output logic                read_err,
   output logic [7:0]          link_read,
   output logic                link_rd_clk,
   output logic                link_wr_start,
   output logic                link_wr_clk,
   input  logic [7:0]          link_write,
   output logic                target_reset
);

   localparam logic [PACE_W-1:0] P_DIV    = PACE_W'(DIV);
   localparam logic [PACE_W-1:0] P_SETTLE = PACE_W'(2 * DIV);
   localparam logic [PACE_W-1:0] P_START  = PACE_W'(START_CYC);
   localparam logic [PACE_W-1:0] P_RST    = PACE_W'(RST_CYC);
   localparam logic [5:0]        LAST_W   = 6'(WORK_BYTES - 1);
   localparam logic [3:0]        LAST_R   = 4'(RESULT_BYTES - 1);

   link_state_e         state_q;
   logic [WORK_W-1:0]   sr_q;
   logic [5:0]          wcnt_q;
   logic [3:0]          rcnt_q;
   logic [RESULT_W-1:0] rbuf_q;
   logic                poll_pend_q;
   logic                go_work, go_read;
   logic                pace_load, pace_done;
   logic [PACE_W-1:0]   pace_val;

`ifdef HOST_LINK_READ_VERIFY_EN
   logic [RESULT_W-1:0] rfirst_q;
   logic                second_q;
   logic [1:0]          attempt_q;
   logic                read_err_q;
   assign read_err = read_err_q;
`else
   assign read_err = 1'b0;
`endif

   ztex_link_pacer #(.W(PACE_W)) u_pacer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (pace_load),
      .value   (pace_val),
      .done    (pace_done)
   );

   // Every state transition reloads the pacer with the length of the state being entered.
   always_comb begin
      go_work   = work_ready && work_valid;
      go_read   = work_ready && !work_valid && (poll_req || poll_pend_q);
      pace_load = pace_done;
      pace_val  = P_DIV;
      unique case (state_q)
         StIdle: begin
            pace_load = go_work || go_read;
            pace_val  = go_work ? P_DIV : P_START;
         end
         StWToggle: if (wcnt_q == LAST_W) pace_val = P_RST;
         StRStart:  pace_val = P_SETTLE;
         StRDone: begin
            pace_load = 1'b1;
            pace_val  = P_START;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         work_ready    <= 1'b0;
         link_read     <= '0;
         link_rd_clk   <= 1'b0;
         link_wr_start <= 1'b0;
         link_wr_clk   <= 1'b0;
         target_reset  <= 1'b1;
         result        <= '0;
         result_valid  <= 1'b0;
         sr_q          <= '0;
         wcnt_q        <= '0;
         rcnt_q        <= '0;
         rbuf_q        <= '0;
         poll_pend_q   <= 1'b0;
`ifdef HOST_LINK_READ_VERIFY_EN
         rfirst_q      <= '0;
         second_q      <= 1'b0;
         attempt_q     <= '0;
         read_err_q    <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
`ifdef HOST_LINK_READ_VERIFY_EN
         read_err_q   <= 1'b0;
`endif
         // Polls arriving around a work load are remembered and served once it completes.
         if (state_q inside {StIdle, StWSetup, StWToggle, StTRst}) begin
            poll_pend_q <= poll_pend_q | poll_req;
         end
         unique case (state_q)
            StIdle: begin
               work_ready <= 1'b1;
               if (go_work) begin
                  work_ready <= 1'b0;
                  sr_q       <= work_data;
                  wcnt_q     <= '0;
                  link_read  <= work_data[7:0];
                  state_q    <= StWSetup;
               end else if (go_read) begin
                  work_ready    <= 1'b0;
                  poll_pend_q   <= 1'b0;
                  rcnt_q        <= '0;
                  link_wr_start <= 1'b1;
                  state_q       <= StRStart;
               end
            end
            StWSetup: if (pace_done) begin
               link_rd_clk <= ~link_rd_clk;
               state_q     <= StWToggle;
            end
            StWToggle: if (pace_done) begin
               if (wcnt_q == LAST_W) begin
                  target_reset <= 1'b1;
                  state_q      <= StTRst;
               end else begin
                  sr_q      <= sr_q >> 8;
                  wcnt_q    <= wcnt_q + 6'd1;
                  link_read <= sr_q[15:8];
                  state_q   <= StWSetup;
               end
            end
            StTRst: if (pace_done) begin
               target_reset <= 1'b0;
               work_ready   <= 1'b1;
               state_q      <= StIdle;
            end
            StRStart: if (pace_done) begin
               link_wr_start <= 1'b0;
               state_q       <= StRSettle;
            end
            StRSettle: if (pace_done) state_q <= StRSample;
            StRSample: if (pace_done) begin
               rbuf_q      <= put_result_byte(rbuf_q, rcnt_q, link_write);
               link_wr_clk <= ~link_wr_clk;
               state_q     <= StRToggle;
            end
            StRToggle: if (pace_done) begin
               if (rcnt_q == LAST_R) begin
                  state_q <= StRDone;
               end else begin
                  rcnt_q  <= rcnt_q + 4'd1;
                  state_q <= StRSample;
               end
            end
            StRDone: begin
`ifdef HOST_LINK_READ_VERIFY_EN
               if (!second_q) begin
                  rfirst_q      <= rbuf_q;
                  second_q      <= 1'b1;
                  rcnt_q        <= '0;
                  link_wr_start <= 1'b1;
                  state_q       <= StRStart;
               end else if (rfirst_q == rbuf_q) begin
                  result       <= rbuf_q;
                  result_valid <= 1'b1;
                  second_q     <= 1'b0;
                  attempt_q    <= '0;
                  work_ready   <= 1'b1;
                  state_q      <= StIdle;
               end else if (attempt_q == 2'd2) begin
                  read_err_q <= 1'b1;
                  second_q   <= 1'b0;
                  attempt_q  <= '0;
                  work_ready <= 1'b1;
                  state_q    <= StIdle;
               end else begin
                  attempt_q     <= attempt_q + 2'd1;
                  second_q      <= 1'b0;
                  rcnt_q        <= '0;
                  link_wr_start <= 1'b1;
                  state_q       <= StRStart;
               end
`else
               result       <= rbuf_q;
               result_valid <= 1'b1;
               work_ready   <= 1'b1;
               state_q      <= StIdle;
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
